// File: rtl/lfsr_checker.sv
// Receive-side LFSR pattern checker: self-seeds from the incoming serial
// stream, verifies the prediction for LOCK_CNT bits, then flywheels the
// local LFSR while counting bit errors and checked bits for BER measurement.
module lfsr_checker #(
  parameter int                  REG_BITS = 16,
  parameter logic [REG_BITS-1:0] TAPS     = 16'hB400,
  parameter int                  LOCK_CNT = 32,
  parameter int                  LOSS_CNT = 8,
  parameter int                  CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  input  logic                din_valid,
  input  logic                clr_err,
  output logic                locked,
  output logic                err_pulse,
  output logic [CNT_BITS-1:0] err_cnt,
  output logic [CNT_BITS-1:0] bit_cnt
);

  localparam int FILL_W  = $clog2(REG_BITS + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(REG_BITS - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_CNT - 1);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [REG_BITS-1:0] state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                err_pulse_d;
  logic [CNT_BITS-1:0] err_cnt_d, bit_cnt_d;
  logic                pred;
  logic [REG_BITS-1:0] shift_din;
  logic [REG_BITS-1:0] shift_pred;

  // Counters stick at all-ones instead of wrapping so a long BER run never
  // reports a misleadingly small number.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  assign pred       = ^(state_q & TAPS);
  assign shift_din  = {state_q[REG_BITS-2:0], din};
  assign shift_pred = {state_q[REG_BITS-2:0], pred};

  // Next-state and counter logic; nothing moves on cycles without din_valid.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt;
    bit_cnt_d   = bit_cnt;

    if (din_valid) begin
      unique case (fsm_q)
        SEED: begin
          state_d = shift_din;
          if (fill_q == FILL_LAST) begin
            fill_d  = '0;
            match_d = '0;
            fsm_d   = VERIFY;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        VERIFY: begin
          state_d = shift_din;
          if (din != pred) begin
            fsm_d  = SEED;
            fill_d = '0;
          end else if (match_q == MATCH_LAST) begin
            // An all-zero register is a dead LFSR (idle line), never a lock.
            fill_d = '0;
            miss_d = '0;
            fsm_d  = (|shift_din) ? LOCKED : SEED;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end
        LOCKED: begin
          // Flywheel: the model runs on its own prediction so received
          // errors cannot corrupt it.
          state_d   = shift_pred;
          bit_cnt_d = sat_inc(bit_cnt);
          if (din != pred) begin
            err_pulse_d = 1'b1;
            err_cnt_d   = sat_inc(err_cnt);
            if (miss_q == MISS_LAST) begin
              miss_d = '0;
              fill_d = '0;
              fsm_d  = SEED;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          fsm_d  = SEED;
          fill_d = '0;
        end
      endcase
    end

    // Clearing wins over a same-cycle increment.
    if (clr_err) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= SEED;
      state_q   <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked    <= (fsm_d == LOCKED);
      err_pulse <= err_pulse_d;
      err_cnt   <= err_cnt_d;
      bit_cnt   <= bit_cnt_d;
    end
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the team's LFSR pattern generator.
- Accepts the generator's serial bit stream and self-synchronises by loading REG_BITS received bits as the seed state.
- Then predicts every following bit and compares it against the received bit, declaring lock or loss of lock from the result.
- Counts bit errors and checked bits for BER measurement on the link under test.

Parameters:
- REG_BITS, 16: LFSR state width, ≥4.
- TAPS, 16'hB400: feedback mask. Must equal the transmitter mask.
- LOCK_CNT, 32: consecutive matching bits required in VERIFY before lock.
- LOSS_CNT, 8: consecutive mismatches while LOCKED that drop lock.
- CNT_BITS, 32: width of err_cnt and bit_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- din  in  1  received serial bit.
- din_valid  in  1  din is sampled only when high. Low cycles freeze all state.
- clr_err  in  1  synchronous clear of err_cnt and bit_cnt.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatching bit while LOCKED.
- err_cnt  out  CNT_BITS  mismatches counted while LOCKED; saturating.
- bit_cnt  out  CNT_BITS  valid bits checked while LOCKED; saturating.

Behaviour:
- LFSR model:
  - pred = XOR-reduce(state & TAPS).
  - Shift: state <= {state[REG_BITS-2:0], newbit}.
  - The transmitter emits each newbit as its serial bit.
- Reset (rst=1 at a clk edge): state=0, fill counter=0, match counter=0, miss counter=0, FSM=SEED, locked=0, err_pulse=0, err_cnt=0, bit_cnt=0. Reset asserted mid-operation aborts everything; no partial lock is retained.
- All transitions below occur only on cycles with din_valid=1. With din_valid=0, registers hold and err_pulse=0.
- SEED:
  - newbit = din; fill counter increments.
  - On the REG_BITS-th bit, go to VERIFY with the match counter cleared.
- VERIFY:
  - newbit = din.
  - din==pred: match counter increments.
  - din!=pred: go back to SEED, fill counter=0.
  - When match counter reaches LOCK_CNT:
    - state nonzero: go to LOCKED.
    - state all-zero (dead LFSR / idle line): go to SEED.
- LOCKED:
  - newbit = pred, the flywheel; received errors do not corrupt the model.
  - bit_cnt increments on every valid bit.
  - On mismatch: err_pulse=1 next cycle, err_cnt increments, miss counter increments.
  - On match: miss counter clears.
  - Miss counter reaching LOSS_CNT: go to SEED, locked=0.
  - err_cnt and bit_cnt hold their values after loss of lock.
- Outputs are registered. locked rises on the cycle after the LOCK_CNT-th matching bit is clocked.
- Counters saturate at all-ones and never wrap.
- clr_err has priority over an increment in the same cycle; result is 0.
- clr_err does not affect the FSM or locked.
- Lock latency with a clean stream and continuous din_valid: REG_BITS+LOCK_CNT valid bits.

Test Plan:
- Clean stream: generator output with TAPS=16'hB400, seed 16'hACE1, continuous valid → locked=1 after bit 48. Then 1000 bits → err_cnt=0, bit_cnt=1000.
- Single bit flips while locked: invert din at locked bits 100 and 200 → two err_pulse cycles, err_cnt=2, locked stays 1, no further errors (flywheel).
- Loss of lock: after lock, drive 8 inverted consecutive bits → err_cnt=8, locked=0. Resume the clean stream → relock 48 bits later. err_cnt still 8.
- Bursty valid: clean stream with din_valid toggling 1/0 every cycle → lock after 48 valid bits (96 cycles). Counters do not move on invalid cycles.
- All-zero input: din=0 with continuous valid for 500 bits → locked never asserts.
- Control collisions:
  - clr_err asserted in the same cycle as a mismatch → err_cnt=0.
  - rst asserted at locked bit 50 → all outputs 0 next cycle; relock takes 48 bits.
